// File: rtl/gate_tt_checker_if.sv
// Handshake and gate-stimulus bundle between a truth-table checker and the
// lab top-level (start/gate output in, gate drive and results out).
interface gate_tt_checker_if;
  logic       start;
  logic       f_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] captured;
  logic [2:0] err_count;

  modport master (
    output start, f_in,
    input  a_out, b_out, busy, done, pass, captured, err_count
  );

  modport slave (
    input  start, f_in,
    output a_out, b_out, busy, done, pass, captured, err_count
  );
endinterface

// File: rtl/gate_tt_checker.sv
// Sweeps a 2-input gate through (a,b) = 00,10,01,11, samples its output after
// a settle time and compares the measured truth table to EXPECTED_TT.
module gate_tt_checker #(
  parameter logic [3:0]  EXPECTED_TT   = 4'b1000,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  gate_tt_checker_if.slave tt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] captured_q, captured_d;
  logic [2:0] err_q, err_d;

  logic       mismatch;
  logic [2:0] err_next;
  logic [1:0] idx_next;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    captured_d = captured_q;
    err_d      = err_q;
    mismatch   = (tt.f_in != EXPECTED_TT[idx_q]);
    err_next   = err_q + {2'b00, mismatch};
    idx_next   = idx_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (tt.start) begin
          idx_d      = 2'd0;
          cnt_d      = 8'd0;
          captured_d = 4'b0000;
          err_d      = 3'd0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_SAMPLE: begin
        captured_d[idx_q] = tt.f_in;
        err_d             = err_next;
        if (idx_q == 2'd3) begin
          // Last vector: the verdict must include the bit sampled on this edge.
          done_d  = 1'b1;
          busy_d  = 1'b0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = (err_next == 3'd0);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_next;
          a_d     = idx_next[0];
          b_d     = idx_next[1];
          state_d = S_SETTLE;
        end
      end

      default: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      cnt_q      <= 8'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      captured_q <= 4'b0000;
      err_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      captured_q <= captured_d;
      err_q      <= err_d;
    end
  end

  assign tt.a_out     = a_q;
  assign tt.b_out     = b_q;
  assign tt.busy      = busy_q;
  assign tt.done      = done_q;
  assign tt.pass      = pass_q;
  assign tt.captured  = captured_q;
  assign tt.err_count = err_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Self-checking bench: four checker instances with different expected tables
// and settle times, each driven by a modelled gate with settle-time glitches.
module tb_gate_tt_checker;

  localparam logic [15:0] EXPS = {4'b0110, 4'b1110, 4'b0111, 4'b1000};
  localparam logic [31:0] SCS  = {8'd4, 8'd1, 8'd2, 8'd2};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       st  [4];
  logic       gl  [4];
  logic [3:0] gt  [4];
  logic       a_o [4];
  logic       b_o [4];
  logic       busy_o [4];
  logic       done_o [4];
  logic       pass_o [4];
  logic [3:0] cap_o  [4];
  logic [2:0] err_o  [4];

  int checks = 0;
  int errors = 0;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      gate_tt_checker_if ifc ();
      gate_tt_checker #(
        .EXPECTED_TT   (EXPS[g*4 +: 4]),
        .SETTLE_CYCLES (int'(SCS[g*8 +: 8]))
      ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tt    (ifc.slave)
      );
      assign ifc.start  = st[g];
      assign ifc.f_in   = gt[g][{ifc.b_out, ifc.a_out}] ^ gl[g];
      assign a_o[g]     = ifc.a_out;
      assign b_o[g]     = ifc.b_out;
      assign busy_o[g]  = ifc.busy;
      assign done_o[g]  = ifc.done;
      assign pass_o[g]  = ifc.pass;
      assign cap_o[g]   = ifc.captured;
      assign err_o[g]   = ifc.err_count;
    end
  endgenerate

  // Reference parameters of each instance, as the model sees them.
  function automatic int settle_of(input int d);
    case (d)
      0: return 2;
      1: return 2;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] exp_of(input int d);
    case (d)
      0: return 4'b1000;
      1: return 4'b0111;
      2: return 4'b1110;
      default: return 4'b0110;
    endcase
  endfunction

  // One full sweep on instance d with gate truth table gtt; start is re-pulsed
  // at cycles spur1/spur2 of the sweep (negative = never).
  task automatic sweep(input int d, input logic [3:0] gtt, input int spur1,
                       input int spur2, input string nm);
    int s;
    int n;
    logic [3:0] exp_cap;
    logic [2:0] exp_err;
    logic       exp_pass;
    logic [1:0] vi;
    logic [3:0] exp_sig;
    s        = settle_of(d);
    n        = 4 * (s + 1);
    exp_cap  = gtt;
    exp_err  = 3'($countones(gtt ^ exp_of(d)));
    exp_pass = (gtt == exp_of(d));
    gt[d]    = gtt;
    @(posedge clk); #1;
    st[d] = 1'b1;
    @(posedge clk); #1;
    st[d] = 1'b0;
    for (int k = 0; k <= n + 1; k++) begin
      vi = 2'(k / (s + 1));
      if (k < n)       exp_sig = {vi[0], vi[1], 1'b1, 1'b0};
      else if (k == n) exp_sig = 4'b0001;
      else             exp_sig = 4'b0000;
      checks++;
      if ({a_o[d], b_o[d], busy_o[d], done_o[d]} !== exp_sig) begin
        errors++;
        $display("FAIL %s abbusydone k=%0d got %b want %b", nm, k,
                 {a_o[d], b_o[d], busy_o[d], done_o[d]}, exp_sig);
      end
      if (k < n) begin
        checks++;
        if (pass_o[d] !== 1'b0) begin
          errors++;
          $display("FAIL %s pass_cleared k=%0d got %b want 0", nm, k, pass_o[d]);
        end
      end else begin
        checks++;
        if ({cap_o[d], err_o[d], pass_o[d]} !== {exp_cap, exp_err, exp_pass}) begin
          errors++;
          $display("FAIL %s result k=%0d got cap=%b err=%0d pass=%b want cap=%b err=%0d pass=%b",
                   nm, k, cap_o[d], err_o[d], pass_o[d], exp_cap, exp_err, exp_pass);
        end
      end
      // Glitch the gate output only while the vector is still settling.
      gl[d] = (k < n && (k % (s + 1)) != s) ? 1'($urandom_range(0, 1)) : 1'b0;
      st[d] = (k == spur1 || k == spur2);
      @(posedge clk); #1;
    end
    st[d] = 1'b0;
    gl[d] = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({a_o[d], b_o[d], busy_o[d], done_o[d], pass_o[d], cap_o[d], err_o[d]} !== 12'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d got %b want 0", d,
                 {a_o[d], b_o[d], busy_o[d], done_o[d], pass_o[d], cap_o[d], err_o[d]});
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    sweep(0, 4'b1000, -1, -1, "and_default");
    sweep(0, 4'b0000, -1, -1, "stuck0");
    sweep(0, 4'b0111, -1, -1, "nand_vs_and");
    sweep(1, 4'b0111, -1, -1, "nand_vs_nand");
    sweep(2, 4'b1110, -1, -1, "or_settle1");
    sweep(3, 4'b0110, -1, -1, "xor_settle4");
  endtask

  task automatic test_start_ignored();
    sweep(0, 4'b1000, 3, 8, "start_while_busy");
  endtask

  task automatic test_reset_mid();
    int s;
    s = settle_of(0);
    gt[0] = 4'b0111;
    @(posedge clk); #1;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (2 * (s + 1) + 1) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({a_o[0], b_o[0], busy_o[0]} !== 3'b011) begin
      errors++;
      $display("FAIL mid_vector2 got %b want 011", {a_o[0], b_o[0], busy_o[0]});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_o[0], b_o[0], busy_o[0], done_o[0], pass_o[0], cap_o[0], err_o[0]} !== 12'd0) begin
      errors++;
      $display("FAIL async_reset got %b want 0",
               {a_o[0], b_o[0], busy_o[0], done_o[0], pass_o[0], cap_o[0], err_o[0]});
    end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({busy_o[0], done_o[0]} !== 2'b00) begin
        errors++;
        $display("FAIL reset_no_done got %b want 00", {busy_o[0], done_o[0]});
      end
    end
    rst_n = 1'b1;
    sweep(0, 4'b1000, -1, -1, "after_reset");
  endtask

  task automatic test_back_to_back();
    int n;
    logic exp_done;
    logic exp_busy;
    n = 4 * (settle_of(0) + 1);
    gt[0] = 4'b1000;
    @(posedge clk); #1;
    st[0] = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k <= 2 * n + 3; k++) begin
      exp_done = (k == n) || (k == 2 * n + 2);
      exp_busy = !(k == n || k == n + 1 || k >= 2 * n + 2);
      checks++;
      if ({busy_o[0], done_o[0]} !== {exp_busy, exp_done}) begin
        errors++;
        $display("FAIL back_to_back k=%0d got busy/done %b want %b", k,
                 {busy_o[0], done_o[0]}, {exp_busy, exp_done});
      end
      if (k == 2 * n + 1) st[0] = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if ({cap_o[0], err_o[0], pass_o[0]} !== {4'b1000, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL back_to_back_result got cap=%b err=%0d pass=%b want cap=1000 err=0 pass=1",
               cap_o[0], err_o[0], pass_o[0]);
    end
  endtask

  task automatic test_random();
    int d;
    int n;
    int sp;
    logic [3:0] gtt;
    for (int r = 0; r < 10; r++) begin
      d   = $urandom_range(0, 3);
      gtt = 4'($urandom);
      n   = 4 * (settle_of(d) + 1);
      sp  = $urandom_range(0, 1) ? int'($urandom_range(0, n - 1)) : -1;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      sweep(d, gtt, sp, -1, "random");
    end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      st[d] = 1'b0;
      gl[d] = 1'b0;
      gt[d] = 4'b0000;
    end
    test_reset();
    test_basic();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
